// File: rtl/lvm_bus_defs.sv
// Shared definitions for the 4-requester 16-bit bus: widths, FSM encoding
// and the round-robin pick helper.
package lvm_bus_defs;
   localparam int DATA_W  = 16;
   localparam int NUM_REQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // First set request after ptr, wrapping; ptr itself is examined last.
   function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                          input logic [1:0]         ptr);
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/mux4way16.sv
// 4-way 16-bit data mux; line selects inp1..inp4.
module mux4way16
   import lvm_bus_defs::*;
(
   input  logic [1:0]        line,
   input  logic [DATA_W-1:0] inp1,
   input  logic [DATA_W-1:0] inp2,
   input  logic [DATA_W-1:0] inp3,
   input  logic [DATA_W-1:0] inp4,
   output logic [DATA_W-1:0] out
);
   always_comb begin
      out = inp1;
      case (line)
         2'd0: out = inp1;
         2'd1: out = inp2;
         2'd2: out = inp3;
         2'd3: out = inp4;
         default: out = inp1;
      endcase
   end
endmodule

// File: rtl/bus_arbiter4x16.sv
// Round-robin arbiter/sequencer for a shared 16-bit bus with four requesters.
// Tenure ends on last beat, beat limit, or owner withdrawal; no idle bubble.
module bus_arbiter4x16
   import lvm_bus_defs::*;
#(
   parameter int MAX_BEATS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req,
   input  logic [3:0]         last,
   input  logic [DATA_W-1:0]  din0,
   input  logic [DATA_W-1:0]  din1,
   input  logic [DATA_W-1:0]  din2,
   input  logic [DATA_W-1:0]  din3,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_last,
   output logic [3:0]         gnt,
   output logic [1:0]         sel,
   output logic               busy
);
   localparam int CW = $clog2(MAX_BEATS + 1);

   state_t        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic       owner_req, acc, at_limit, tenure_end;
   logic [1:0] pick;

   assign owner_req  = req[owner_q];
   assign busy       = (state_q == GRANT);
   assign out_valid  = busy & owner_req;
   assign out_last   = last[owner_q] & out_valid;
   assign sel        = owner_q;
   assign gnt        = busy ? (4'd1 << owner_q) : 4'd0;
   assign acc        = out_valid & out_ready;
   assign at_limit   = acc && ((cnt_q + CW'(1)) == CW'(MAX_BEATS));
   // Withdrawal ends the tenure even without an accepted beat.
   assign tenure_end = busy & (~owner_req | (acc & last[owner_q]) | at_limit);
   assign pick       = rr_pick(req, ptr_q);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               owner_d = pick;
               ptr_d   = pick;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (tenure_end) begin
               cnt_d = '0;
               if (|req) begin
                  owner_d = pick;
                  ptr_d   = pick;
               end else begin
                  state_d = IDLE;
               end
            end else if (acc) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 2'd0;
         ptr_q   <= 2'd3;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   mux4way16 u_mux (
      .line (sel),
      .inp1 (din0),
      .inp2 (din1),
      .inp3 (din2),
      .inp4 (din3),
      .out  (out_data)
   );
endmodule

// File: tb/tb_bus_arbiter4x16.sv
// Scoreboard bench: directed plan plus random traffic against a queue-free
// integer reference model of the round-robin tenure rules.
module tb_bus_arbiter4x16;
   localparam int MAXB = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req, last;
   logic [15:0] din0, din1, din2, din3;
   logic        out_ready;
   logic        out_valid, out_last, busy;
   logic [15:0] out_data;
   logic [3:0]  gnt;
   logic [1:0]  sel;

   bus_arbiter4x16 #(.MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .din0(din0), .din1(din1), .din2(din2), .din3(din3),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .gnt(gnt), .sel(sel), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  gnt;
      logic [1:0]  sel;
      logic        busy;
      logic        valid;
      logic        last;
      logic [15:0] data;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // Reference model state
   bit  m_busy;
   int  m_owner, m_ptr, m_cnt;

   function automatic int next_owner(input logic [3:0] r, input int p);
      for (int k = 1; k <= 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic cyc(input logic rs, input logic [3:0] rq, input logic [3:0] ls,
                      input logic rdy, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
      exp_t        e;
      logic [15:0] dd [4];
      bit          v, acc, fin;
      int          nx;
      @(posedge clk);
      #1;
      rst_n = rs; req = rq; last = ls; out_ready = rdy;
      din0 = d0; din1 = d1; din2 = d2; din3 = d3;
      dd[0] = d0; dd[1] = d1; dd[2] = d2; dd[3] = d3;
      if (!rs) begin
         m_busy = 0; m_owner = 0; m_ptr = 3; m_cnt = 0;
      end
      v       = m_busy && rq[m_owner];
      e.gnt   = m_busy ? 4'(1 << m_owner) : 4'd0;
      e.sel   = 2'(m_owner);
      e.busy  = m_busy;
      e.valid = v;
      e.last  = v && ls[m_owner];
      e.data  = dd[m_owner];
      q.push_back(e);
      if (rs) begin
         nx = next_owner(rq, m_ptr);
         if (!m_busy) begin
            if (nx >= 0) begin
               m_busy = 1; m_owner = nx; m_ptr = nx; m_cnt = 0;
            end
         end else begin
            acc = v && rdy;
            if (acc) m_cnt++;
            fin = !rq[m_owner] || (acc && ls[m_owner]) || (acc && m_cnt == MAXB);
            if (fin) begin
               m_cnt = 0;
               if (nx >= 0) begin
                  m_owner = nx; m_ptr = nx;
               end else begin
                  m_busy = 0;
               end
            end
         end
      end
   endtask

   task automatic dcyc(input logic rs, input logic [3:0] rq, input logic [3:0] ls,
                       input logic rdy);
      cyc(rs, rq, ls, rdy, 16'h0000, 16'hFFFF, 16'h5555, 16'h00FF);
   endtask

   // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
   always @(negedge clk) begin
      exp_t e, a;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = '{gnt: gnt, sel: sel, busy: busy, valid: out_valid, last: out_last, data: out_data};
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs t=%0t got gnt=%b sel=%0d busy=%b v=%b l=%b d=%h want gnt=%b sel=%0d busy=%b v=%b l=%b d=%h",
                     $time, a.gnt, a.sel, a.busy, a.valid, a.last, a.data,
                     e.gnt, e.sel, e.busy, e.valid, e.last, e.data);
         end
      end
   end

   initial begin
      int b;
      rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
      din0 = '0; din1 = '0; din2 = '0; din3 = '0;
      m_busy = 0; m_owner = 0; m_ptr = 3; m_cnt = 0;

      // 1: reset mid-tenure, then single requester
      dcyc(0, 4'b0000, 4'b0000, 0);
      dcyc(1, 4'b0100, 4'b0000, 0);
      dcyc(1, 4'b0100, 4'b0000, 0);
      dcyc(0, 4'b0100, 4'b0000, 0);
      dcyc(1, 4'b0001, 4'b0000, 0);
      dcyc(1, 4'b0001, 4'b0000, 0);
      // 2: round robin
      dcyc(0, 4'b0000, 4'b0000, 0);
      repeat (6) dcyc(1, 4'b1111, 4'b1111, 1);
      // 3: backpressure on owner 2
      dcyc(0, 4'b0000, 4'b0000, 0);
      dcyc(1, 4'b0100, 4'b0000, 0);
      repeat (3) dcyc(1, 4'b0100, 4'b0000, 0);
      repeat (3) dcyc(1, 4'b0100, 4'b0000, 1);
      // 4: beat limit
      dcyc(0, 4'b0000, 4'b0000, 0);
      repeat (12) dcyc(1, 4'b1010, 4'b0000, 1);
      // 5: withdrawal
      dcyc(0, 4'b0000, 4'b0000, 0);
      dcyc(1, 4'b0001, 4'b0000, 0);
      dcyc(1, 4'b0001, 4'b0000, 0);
      repeat (3) dcyc(1, 4'b0100, 4'b0000, 1);
      // 6: sole requester
      dcyc(0, 4'b0000, 4'b0000, 0);
      repeat (6) dcyc(1, 4'b0010, 4'b0010, 1);
      dcyc(1, 4'b0000, 4'b0000, 1);
      dcyc(1, 4'b0000, 4'b0000, 1);

      // Random traffic with sticky requests and occasional reset
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] r;
         r = req;
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
         cyc(($urandom_range(0, 299) != 0), r,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
             ($urandom_range(0, 3) != 0),
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end

      b = 0;
      while (q.size() > 0 && b < 10) begin
         @(negedge clk);
         b++;
      end
      #1;
      if (q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_arbiter4x16.md
# bus_arbiter4x16

Round-robin arbiter and sequencer for a shared 16-bit bus fed by four requesters. It owns the select line of a 4-way 16-bit data mux. It grants the bus to one requester per tenure and forwards that requester's beats through a valid/ready handshake. A tenure ends on the last beat, on a beat-count limit, or when the owner withdraws. The block sits between the four bus masters and the single downstream consumer.

## Interface
Parameters:
- MAX_BEATS, 8: maximum accepted beats per tenure before forced release; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  4  req[i] high: requester i has a beat available or wants the bus.
- last  in  4  last[i] high: requester i's current beat is the final beat of its packet.
- din0, din1, din2, din3  in  16 each  data from requesters 0–3.
- out_ready  in  1  consumer accepts a beat this cycle.
- out_valid  out  1  beat present on out_data.
- out_data  out  16  data of the current owner.
- out_last  out  1  current beat is the final beat.
- gnt  out  4  one-hot grant; 0000 when idle.
- sel  out  2  binary index of the owner; drives the mux select.
- busy  out  1  a tenure is active.

## Operation
- States: IDLE and GRANT.
- Registered state:
  - state.
  - owner (2b).
  - ptr (2b): last granted requester. Reset value 3, so requester 0 has first priority.
  - beat count, $clog2(MAX_BEATS+1) bits.
- Arbitration:
  - Scan req starting at ptr+1 and wrapping mod 4; ptr itself is scanned last.
  - The first set bit becomes the owner.
  - Arbitration runs in IDLE, and in GRANT on the cycle a tenure ends.
- IDLE:
  - If any req is high: go to GRANT with the new owner, set ptr = owner, clear count.
  - Otherwise stay in IDLE.
- GRANT:
  - Combinational outputs: out_valid = req[owner], out_data = din[owner], out_last = last[owner] & out_valid.
  - A beat is accepted when out_valid & out_ready; each accepted beat increments count.
  - The tenure ends on any of:
    - (a) an accepted beat with out_last = 1;
    - (b) an accepted beat that makes count equal MAX_BEATS;
    - (c) req[owner] = 0, meaning the owner withdrew.
  - On end: re-arbitrate. With no gap, go to GRANT with the next owner if any req is high, else go to IDLE.
- A sole requester that ends a tenure and still requests is re-granted immediately (wrap-around to itself).
- Derived outputs:
  - gnt = one-hot(owner) in GRANT, 0000 in IDLE.
  - sel = owner; it holds its value in IDLE.
  - busy = (state == GRANT).
- Backpressure: with out_ready low, the owner, count and outputs all hold.
- Reset values: state IDLE, gnt 0000, sel 00, busy 0, out_valid 0, out_last 0, count 0, ptr 3. out_data equals din0, since sel is 00.
- Reset asserted mid-tenure forces all of the above asynchronously. An in-flight beat is dropped and no partial-packet state is kept.

## Timing
- Grant latency: req rising in IDLE gives gnt and busy at the next rising edge. The first beat is presentable in that same cycle.
- Back-to-back tenures: the new owner's gnt appears in the cycle right after the release beat. No idle bubble.
- Throughput: one beat per cycle while out_ready is high.
- out_valid, out_data and out_last are combinational from registered sel and the live req, last and din inputs. The consumer registers them if timing requires.
- Withdrawal (c) costs one cycle with out_valid = 0 before the next grant.

## Structure
- Shared package lvm_bus_defs:
  - DATA_W = 16.
  - NUM_REQ = 4.
  - State encodings: IDLE = 1'b0, GRANT = 1'b1.
- Sub-module: one existing mux4way16 instance. Its line input is driven by sel, inp1–inp4 by din0–din3, and out drives out_data.
- The round-robin scan and the FSM stay in this module.

## Test plan
Common data: din0=16'h0000, din1=16'hFFFF, din2=16'h5555, din3=16'h00FF.
1. Reset: assert rst_n=0 mid-tenure with gnt=0100 → gnt=0000, out_valid=0 and busy=0 immediately. Release with req=0001 → gnt=0001 one edge later, out_data=16'h0000.
2. Round-robin: req=1111, last=1111, out_ready=1 → gnt goes 0001, 0010, 0100, 1000, 0001 on consecutive cycles. out_data goes 0000, FFFF, 5555, 00FF.
3. Backpressure: owner 2, last=0, out_ready=0 for 3 cycles → out_data holds 16'h5555, gnt holds 0100, count unchanged. The first beat is accepted when out_ready returns.
4. Beat limit: req=1010, last=0000, MAX_BEATS=8, out_ready=1 → owner 1 gets exactly 8 beats of 16'hFFFF. gnt=1000 on the next cycle.
5. Withdrawal: owner 0, req[0] drops with no last, req=0100 → one cycle with out_valid=0, then gnt=0100. No beat is counted for owner 0.
6. Sole requester: req=0010, last=0010 continuous → gnt stays 0010 and out_valid=1 every cycle, with one packet per cycle.
